mc_mb_sequencer: RTL and testbench

Sequences one inter macroblock through the motion-compensation datapath. It walks the 16 luma 4x4 blocks in H.264 block order, then the 4 Cb and 4 Cr 4x4 blocks. For each block it issues four reference-row fetch requests with motion-vector-offset addresses, then waits for the MC controller to report that the block's residuals are complete. It sits between the MB-level inter control and the reference-pixel memory / mc_controller pair, and drives the ccin flag that controller consumes.

---
 rtl/mc_mb_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_mc_mb_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mb_sequencer.sv
// mc_mb_sequencer: steps one inter macroblock through the MC datapath.
// It walks the 16 luma 4x4 blocks in H.264 order, then 4 Cb and 4 Cr blocks.
// For each block it requests four reference rows at motion-vector-offset
// addresses, then waits for the MC controller to finish that block.
module mc_mb_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int MV_W      = 8,
  parameter int PITCH     = 176,
  parameter int LUMA_BASE = 0,
  parameter int CB_BASE   = 25344,
  parameter int CR_BASE   = 31680
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mb_start,
  output logic                     mb_ready,
  input  logic [6:0]               mb_x,
  input  logic [6:0]               mb_y,
  input  logic signed [MV_W-1:0]   mv_x,
  input  logic signed [MV_W-1:0]   mv_y,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_ack,
  output logic [1:0]               blk_row,
  output logic                     ccin,
  output logic [3:0]               blk_idx,
  input  logic                     blk_done,
  output logic                     mb_done,
  output logic                     busy
);

  // Two guard bits let negative intermediate coordinates wrap cleanly.
  localparam int CALC_W = ADDR_W + 2;
  localparam int CPITCH = PITCH / 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_BLK = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              blk_idx_q, blk_idx_d;
  logic                    ccin_q, ccin_d;
  logic [1:0]              blk_row_q, blk_row_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [6:0]              mbx_q, mbx_d, mby_q, mby_d;
  logic signed [MV_W-1:0]  mvx_q, mvx_d, mvy_q, mvy_d;

  // Reference address of the first pixel of one 4-pixel row of a 4x4 block.
  // Luma blocks follow the 8x8-then-4x4 scan; chroma uses a halved MV
  // (arithmetic shift, so negative vectors round toward minus infinity).
  // No clipping: the result simply wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] blk_addr(
    input logic                    ch,
    input logic [3:0]              idx,
    input logic [1:0]              row,
    input logic [6:0]              mbx,
    input logic [6:0]              mby,
    input logic signed [MV_W-1:0]  mvx,
    input logic signed [MV_W-1:0]  mvy
  );
    logic signed [CALC_W-1:0] mbx_s, mby_s, bx_s, by_s, row_s;
    logic signed [CALC_W-1:0] mvx_s, mvy_s, x_s, y_s, base_s, pitch_s;
    logic [ADDR_W-1:0]        sum;
    mbx_s = CALC_W'($signed({1'b0, mbx}));
    mby_s = CALC_W'($signed({1'b0, mby}));
    row_s = CALC_W'($signed({1'b0, row}));
    mvx_s = CALC_W'(mvx);
    mvy_s = CALC_W'(mvy);
    if (!ch) begin
      bx_s    = CALC_W'($signed({1'b0, idx[2], idx[0]}));
      by_s    = CALC_W'($signed({1'b0, idx[3], idx[1]}));
      x_s     = (mbx_s <<< 4) + (bx_s <<< 2) + mvx_s;
      y_s     = (mby_s <<< 4) + (by_s <<< 2) + row_s + mvy_s;
      base_s  = CALC_W'(LUMA_BASE);
      pitch_s = CALC_W'(PITCH);
    end else begin
      bx_s    = CALC_W'($signed({1'b0, idx[0]}));
      by_s    = CALC_W'($signed({1'b0, idx[1]}));
      x_s     = (mbx_s <<< 3) + (bx_s <<< 2) + (mvx_s >>> 1);
      y_s     = (mby_s <<< 3) + (by_s <<< 2) + row_s + (mvy_s >>> 1);
      base_s  = idx[2] ? CALC_W'(CR_BASE) : CALC_W'(CB_BASE);
      pitch_s = CALC_W'(CPITCH);
    end
    sum = ADDR_W'(base_s + y_s * pitch_s + x_s);
    return sum;
  endfunction

  // Next-state logic: block walk, row stepping and address of the next request.
  always_comb begin
    state_d   = state_q;
    blk_idx_d = blk_idx_q;
    ccin_d    = ccin_q;
    blk_row_d = blk_row_q;
    mbx_d     = mbx_q;
    mby_d     = mby_q;
    mvx_d     = mvx_q;
    mvy_d     = mvy_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        if (mb_start) begin
          mbx_d     = mb_x;
          mby_d     = mb_y;
          mvx_d     = mv_x;
          mvy_d     = mv_y;
          blk_idx_d = 4'd0;
          ccin_d    = 1'b0;
          blk_row_d = 2'd0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (rd_ack) begin
          if (blk_row_q == 2'd3) begin
            state_d = WAIT_BLK;
          end else begin
            blk_row_d = blk_row_q + 2'd1;
          end
        end
      end
      WAIT_BLK: begin
        if (blk_done) begin
          if (ccin_q && (blk_idx_q == 4'd7)) begin
            state_d = DONE;
          end else begin
            if (!ccin_q && (blk_idx_q == 4'd15)) begin
              ccin_d    = 1'b1;
              blk_idx_d = 4'd0;
            end else begin
              blk_idx_d = blk_idx_q + 4'd1;
            end
            blk_row_d = 2'd0;
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The address is registered ahead of time so it is valid on the first
    // FETCH cycle and holds steady while a request waits for rd_ack.
    if (state_d == FETCH) begin
      addr_d = blk_addr(ccin_d, blk_idx_d, blk_row_d, mbx_d, mby_d, mvx_d, mvy_d);
    end
  end

  // Control registers, cleared by synchronous reset to abort any macroblock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      blk_idx_q <= 4'd0;
      ccin_q    <= 1'b0;
      blk_row_q <= 2'd0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      blk_idx_q <= blk_idx_d;
      ccin_q    <= ccin_d;
      blk_row_q <= blk_row_d;
      addr_q    <= addr_d;
    end
  end

  // Macroblock position and motion vector captured on accept.
  always_ff @(posedge clk) begin
    mbx_q <= mbx_d;
    mby_q <= mby_d;
    mvx_q <= mvx_d;
    mvy_q <= mvy_d;
  end

  assign mb_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rd_req   = (state_q == FETCH);
  assign mb_done  = (state_q == DONE);
  assign rd_addr  = addr_q;
  assign blk_row  = blk_row_q;
  assign ccin     = ccin_q;
  assign blk_idx  = blk_idx_q;

endmodule

// File: tb/tb_mc_mb_sequencer.sv
// Testbench for mc_mb_sequencer: drives macroblocks with random handshake
// gaps and compares every row request against a reference address model.
module tb_mc_mb_sequencer;

  logic              clk = 1'b0;
  logic              reset;
  logic              mb_start;
  logic              mb_ready;
  logic [6:0]        mb_x, mb_y;
  logic signed [7:0] mv_x, mv_y;
  logic              rd_req;
  logic [15:0]       rd_addr;
  logic              rd_ack;
  logic [1:0]        blk_row;
  logic              ccin;
  logic [3:0]        blk_idx;
  logic              blk_done;
  logic              mb_done;
  logic              busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  row;
    logic        ch;
    logic [3:0]  idx;
  } req_t;

  req_t obs_q[$];
  int   n_done;
  int   stab_err;
  int   timed_out;
  logic ready_before;
  logic ready_after;

  mc_mb_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .mb_start (mb_start),
    .mb_ready (mb_ready),
    .mb_x     (mb_x),
    .mb_y     (mb_y),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .blk_row  (blk_row),
    .ccin     (ccin),
    .blk_idx  (blk_idx),
    .blk_done (blk_done),
    .mb_done  (mb_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic int floor_half(input int v);
    return (v >= 0) ? v / 2 : -((1 - v) / 2);
  endfunction

  // Request number i (0..95) of a macroblock: 24 blocks of 4 rows,
  // 16 luma blocks in 8x8-quadrant order, then Cb 0-3 and Cr 0-3.
  function automatic req_t model_req(input int i, input int mbx, input int mby,
                                     input int mvx, input int mvy);
    int blk, row, ch, k, q, s, bx, by, x, y, a;
    req_t r;
    blk = i / 4;
    row = i % 4;
    ch  = (blk >= 16) ? 1 : 0;
    k   = ch ? blk - 16 : blk;
    if (ch == 0) begin
      q  = k / 4;
      s  = k % 4;
      bx = 2 * (q % 2) + (s % 2);
      by = 2 * (q / 2) + (s / 2);
      x  = 16 * mbx + 4 * bx + mvx;
      y  = 16 * mby + 4 * by + row + mvy;
      a  = 0 + y * 176 + x;
    end else begin
      s  = k % 4;
      x  = 8 * mbx + 4 * (s % 2) + floor_half(mvx);
      y  = 8 * mby + 4 * (s / 2) + row + floor_half(mvy);
      a  = ((k / 4) == 1 ? 31680 : 25344) + y * 88 + x;
    end
    r.addr = a[15:0];
    r.row  = row[1:0];
    r.ch   = ch[0];
    r.idx  = k[3:0];
    return r;
  endfunction

  function automatic string fmt(input req_t r);
    return $sformatf("addr=%0d row=%0d ccin=%0b idx=%0d", r.addr, r.row, r.ch, r.idx);
  endfunction

  // Runs one macroblock, acking requests after random gaps and reporting
  // block completion after random waits; records what the DUT presented.
  task automatic run_mb(input int mbx, input int mby, input int mvx, input int mvy,
                        input int amin, input int amax, input int dmin, input int dmax,
                        input bit noise, input bit poke);
    int   agap, dgap, cyc, tail;
    bit   pending, seen_done;
    req_t cur, held;
    obs_q.delete();
    n_done = 0; stab_err = 0; timed_out = 0; ready_after = 1'b0;
    pending = 1'b0; seen_done = 1'b0; tail = 0; cyc = 0; held = '0;
    agap = int'($urandom_range(amax, amin));
    dgap = int'($urandom_range(dmax, dmin));
    @(posedge clk); #1;
    ready_before = mb_ready;
    mb_start = 1'b1;
    mb_x = mbx[6:0]; mb_y = mby[6:0]; mv_x = mvx[7:0]; mv_y = mvy[7:0];
    rd_ack = 1'b0; blk_done = 1'b0;
    while (tail < 4) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 4000) begin
        timed_out = 1;
        break;
      end
      mb_start = 1'b0; rd_ack = 1'b0; blk_done = 1'b0;
      if (seen_done) begin
        if (tail == 0) ready_after = mb_ready;
        tail++;
      end
      if (mb_done) begin
        n_done++;
        seen_done = 1'b1;
      end
      if (rd_req) begin
        cur = '{rd_addr, blk_row, ccin, blk_idx};
        if (pending && (cur !== held)) stab_err++;
        if (agap == 0) begin
          rd_ack = 1'b1;
          obs_q.push_back(cur);
          pending = 1'b0;
          agap = int'($urandom_range(amax, amin));
        end else begin
          agap--;
          pending = 1'b1;
          held = cur;
        end
        if (noise && ($urandom_range(1, 0) == 1)) blk_done = 1'b1;
      end else begin
        if (pending) stab_err++;
        pending = 1'b0;
        if (busy && !mb_done) begin
          if (dgap == 0) begin
            blk_done = 1'b1;
            dgap = int'($urandom_range(dmax, dmin));
          end else begin
            dgap--;
          end
        end
      end
      if (poke && busy && !seen_done && ($urandom_range(3, 0) == 0)) begin
        mb_start = 1'b1;
        mb_x = 7'($urandom); mb_y = 7'($urandom);
        mv_x = 8'($urandom); mv_y = 8'($urandom);
      end
    end
    mb_start = 1'b0; rd_ack = 1'b0; blk_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mb_start = 1'b0; rd_ack = 1'b0; blk_done = 1'b0;
    mb_x = '0; mb_y = '0; mv_x = '0; mv_y = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mb_ready !== 1'b1) begin errors++; $display("FAIL reset_mb_ready: got %b want 1", mb_ready); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    checks++; if (rd_addr !== 16'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (blk_row !== 2'd0) begin errors++; $display("FAIL reset_blk_row: got %0d want 0", blk_row); end
    checks++; if (ccin !== 1'b0) begin errors++; $display("FAIL reset_ccin: got %b want 0", ccin); end
    checks++; if (blk_idx !== 4'd0) begin errors++; $display("FAIL reset_blk_idx: got %0d want 0", blk_idx); end
    checks++; if (mb_done !== 1'b0) begin errors++; $display("FAIL reset_mb_done: got %b want 0", mb_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_basic_order();
    int   pos [11] = '{0, 1, 2, 3, 4, 8, 64, 65, 66, 67, 80};
    int   want[11] = '{0, 176, 352, 528, 4, 704, 25344, 25432, 25520, 25608, 31680};
    req_t got, exp_r;
    run_mb(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: got %0d want 0", timed_out); end
    checks++; if (ready_before !== 1'b1) begin errors++; $display("FAIL basic_ready_before: got %b want 1", ready_before); end
    checks++; if (obs_q.size() != 96) begin errors++; $display("FAIL basic_ack_count: got %0d want 96", obs_q.size()); end
    for (int j = 0; j < 11; j++) begin
      got = (pos[j] < obs_q.size()) ? obs_q[pos[j]] : '0;
      checks++;
      if (got.addr !== want[j][15:0]) begin
        errors++; $display("FAIL basic_addr[%0d]: got %0d want %0d", pos[j], got.addr, want[j]);
      end
    end
    got = (64 < obs_q.size()) ? obs_q[64] : '0;
    checks++; if ((got.ch !== 1'b1) || (got.idx !== 4'd0)) begin errors++; $display("FAIL basic_cb0_tag: got ccin=%b idx=%0d want ccin=1 idx=0", got.ch, got.idx); end
    got = (80 < obs_q.size()) ? obs_q[80] : '0;
    checks++; if ((got.ch !== 1'b1) || (got.idx !== 4'd4)) begin errors++; $display("FAIL basic_cr0_tag: got ccin=%b idx=%0d want ccin=1 idx=4", got.ch, got.idx); end
    for (int i = 0; i < 96; i++) begin
      exp_r = model_req(i, 0, 0, 0, 0);
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++;
      if (got !== exp_r) begin errors++; $display("FAIL basic_seq[%0d]: got %s want %s", i, fmt(got), fmt(exp_r)); end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL basic_mb_done_count: got %0d want 1", n_done); end
    checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", ready_after); end
  endtask

  task automatic test_mv_offset();
    req_t got, exp_r;
    run_mb(1, 1, -3, 2, 0, 1, 0, 1, 1'b0, 1'b0);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL mv_timeout: got %0d want 0", timed_out); end
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++; if (got.addr !== 16'd3181) begin errors++; $display("FAIL mv_luma0: got %0d want 3181", got.addr); end
    got = (obs_q.size() > 64) ? obs_q[64] : '0;
    checks++; if (got.addr !== 16'd26142) begin errors++; $display("FAIL mv_cb0: got %0d want 26142", got.addr); end
    for (int i = 0; i < 96; i++) begin
      exp_r = model_req(i, 1, 1, -3, 2);
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++;
      if (got !== exp_r) begin errors++; $display("FAIL mv_seq[%0d]: got %s want %s", i, fmt(got), fmt(exp_r)); end
    end
  endtask

  task automatic test_slow_ack();
    req_t got, exp_r;
    run_mb(5, 7, 9, -6, 3, 3, 1, 3, 1'b1, 1'b0);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL slow_timeout: got %0d want 0", timed_out); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL slow_stability: got %0d changes want 0", stab_err); end
    checks++; if (obs_q.size() != 96) begin errors++; $display("FAIL slow_ack_count: got %0d want 96", obs_q.size()); end
    for (int i = 0; i < 96; i++) begin
      exp_r = model_req(i, 5, 7, 9, -6);
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++;
      if (got !== exp_r) begin errors++; $display("FAIL slow_seq[%0d]: got %s want %s", i, fmt(got), fmt(exp_r)); end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL slow_mb_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_random_mb();
    int   mbx, mby, mvx, mvy, bad;
    req_t got, exp_r;
    for (int n = 0; n < 3; n++) begin
      mbx = int'($urandom_range(10, 0));
      mby = int'($urandom_range(8, 0));
      mvx = int'($urandom_range(255, 0)) - 128;
      mvy = int'($urandom_range(255, 0)) - 128;
      run_mb(mbx, mby, mvx, mvy, 0, 3, 0, 4, 1'b1, 1'b1);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL rand%0d_timeout: got %0d want 0", n, timed_out); end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL rand%0d_stability: got %0d want 0", n, stab_err); end
      checks++; if (obs_q.size() != 96) begin errors++; $display("FAIL rand%0d_ack_count: got %0d want 96", n, obs_q.size()); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL rand%0d_mb_done_count: got %0d want 1", n, n_done); end
      checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL rand%0d_ready_after: got %b want 1", n, ready_after); end
      bad = 0;
      for (int i = 0; i < 96; i++) begin
        exp_r = model_req(i, mbx, mby, mvx, mvy);
        got = (i < obs_q.size()) ? obs_q[i] : '0;
        checks++;
        if (got !== exp_r) begin
          errors++;
          if (bad < 4) $display("FAIL rand%0d_seq[%0d]: got %s want %s", n, i, fmt(got), fmt(exp_r));
          bad++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   found;
    int   extra_done, extra_req;
    req_t got, exp_r;
    @(posedge clk); #1;
    mb_start = 1'b1; mb_x = 7'd3; mb_y = 7'd2; mv_x = 8'sd5; mv_y = -8'sd7;
    rd_ack = 1'b0; blk_done = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      @(posedge clk); #1;
      mb_start = 1'b0;
      if (rd_req && !ccin && (blk_idx == 4'd9) && (blk_row == 2'd1)) found = 1'b1;
      else begin
        rd_ack = rd_req;
        blk_done = busy && !rd_req;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_reach_blk9: got %b want 1", found); end
    reset = 1'b1; rd_ack = 1'b1; blk_done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; rd_ack = 1'b0;
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL rstmid_rd_req: got %b want 0", rd_req); end
    checks++; if (mb_ready !== 1'b1) begin errors++; $display("FAIL rstmid_mb_ready: got %b want 1", mb_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if ((blk_idx !== 4'd0) || (ccin !== 1'b0)) begin errors++; $display("FAIL rstmid_blk: got idx=%0d ccin=%b want idx=0 ccin=0", blk_idx, ccin); end
    extra_done = 0; extra_req = 0;
    rd_ack = 1'b1; blk_done = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (mb_done) extra_done++;
      if (rd_req) extra_req++;
    end
    rd_ack = 1'b0; blk_done = 1'b0;
    checks++; if (extra_done != 0) begin errors++; $display("FAIL rstmid_no_mb_done: got %0d want 0", extra_done); end
    checks++; if (extra_req != 0) begin errors++; $display("FAIL rstmid_no_rd_req: got %0d want 0", extra_req); end
    run_mb(2, 5, -1, -1, 0, 1, 0, 2, 1'b0, 1'b0);
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++; if ((got.idx !== 4'd0) || (got.ch !== 1'b0) || (got.row !== 2'd0)) begin errors++; $display("FAIL rstmid_restart: got %s want idx=0 ccin=0 row=0", fmt(got)); end
    for (int i = 0; i < 96; i++) begin
      exp_r = model_req(i, 2, 5, -1, -1);
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++;
      if (got !== exp_r) begin errors++; $display("FAIL rstmid_seq[%0d]: got %s want %s", i, fmt(got), fmt(exp_r)); end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL rstmid_mb_done_count: got %0d want 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_mv_offset();
    test_slow_ack();
    test_random_mb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
